// File: rtl/stack_machine_pkg.sv
// Shared types and helpers for the stack_machine evaluation engine.
// Optional build macro: STACK_SAT_EN (see stack_machine.sv).
package stack_machine_pkg;

   typedef enum logic [3:0] {
      OpNop  = 4'b0000,
      OpAdd  = 4'b0100,
      OpMul  = 4'b0101,
      OpPush = 4'b0110,
      OpPop  = 4'b0111,
      OpSub  = 4'b1000,
      OpDup  = 4'b1001,
      OpSwap = 4'b1010,
      OpClr  = 4'b1011
   } opcode_e;

   typedef enum logic [1:0] {
      StIdle,
      StMulRun,
      StMulWb
   } state_e;

   // Signed overflow of n +/- t judged from the sign bits only.
   function automatic logic add_sub_ovf(input logic n_msb, input logic t_msb,
                                        input logic r_msb, input logic is_sub);
      logic t_eff;
      t_eff = is_sub ? ~t_msb : t_msb;
      return (n_msb == t_eff) && (r_msb != n_msb);
   endfunction

endpackage

// File: rtl/seq_mult.sv
// WIDTH-cycle radix-2 shift-add signed multiplier working on operand magnitudes.
// done is high during the final iteration cycle; product is valid from the next cycle
// and held until the following start.
module seq_mult #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               neg_q;
   logic               busy_q;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
   always_comb begin
      mag_a = a[WIDTH-1] ? -a : a;
      mag_b = b[WIDTH-1] ? -b : b;
   end

   // Load on start, then one conditional add and shift per cycle for WIDTH cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, mag_a};
         mplier_q <= mag_b;
         acc_q    <= '0;
         cnt_q    <= CW'(WIDTH);
         neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == CW'(1));
   assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/stack_machine.sv
// RPN evaluation engine: valid/ready command stack with ADD/SUB/MUL/DUP/SWAP/CLR.
// Build macro STACK_SAT_EN: when defined, overflowing ADD/SUB/MUL results saturate
// instead of wrapping. Handshake and latency do not change.
import stack_machine_pkg::*;

module stack_machine #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] input_data,
   output logic [WIDTH-1:0] output_data,
   output logic             done,
   output logic             err,
   output logic             overflow,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

`ifdef STACK_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [WIDTH-1:0]   mem [DEPTH];
   state_e             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [WIDTH-1:0]   top_q;
   logic               done_q, err_q, ovf_q, empty_q, full_q;

   logic [AW-1:0]      t_idx, n_idx, p_idx;
   logic [CNT_W-1:0]   cnt_inc, cnt_dec;
   logic [WIDTH-1:0]   nxt_val;
   logic               reject;
   logic [WIDTH-1:0]   add_raw, sub_raw, add_res, sub_res, mul_res;
   logic               add_ovf, sub_ovf, mul_ovf;
   logic [WIDTH:0]     prod_hi;
   logic               mult_start, mult_busy, mult_done;
   logic [2*WIDTH-1:0] mult_product;

   // Stack addressing: top at count-1, next at count-2, push slot at count.
   always_comb begin
      t_idx   = AW'(count_q - CNT_W'(1));
      n_idx   = AW'(count_q - CNT_W'(2));
      p_idx   = AW'(count_q);
      cnt_inc = count_q + CNT_W'(1);
      cnt_dec = count_q - CNT_W'(1);
      nxt_val = mem[n_idx];
   end

   // Rejection decode for the command presented in IDLE.
   always_comb begin
      reject = 1'b0;
      case (opcode)
         OpNop, OpClr:                 reject = 1'b0;
         OpPush, OpDup:                reject = full_q;
         OpPop:                        reject = empty_q;
         OpAdd, OpSub, OpMul, OpSwap:  reject = (count_q < CNT_W'(2));
         default:                      reject = 1'b1;
      endcase
   end

   // Arithmetic results and overflow; the true sign on ADD/SUB overflow is N's sign.
   always_comb begin
      add_raw = nxt_val + top_q;
      sub_raw = nxt_val - top_q;
      add_ovf = add_sub_ovf(nxt_val[WIDTH-1], top_q[WIDTH-1], add_raw[WIDTH-1], 1'b0);
      sub_ovf = add_sub_ovf(nxt_val[WIDTH-1], top_q[WIDTH-1], sub_raw[WIDTH-1], 1'b1);
      prod_hi = mult_product[2*WIDTH-1:WIDTH-1];
      mul_ovf = !((&prod_hi) || (~|prod_hi));
`ifdef STACK_SAT_EN
      add_res = add_ovf ? (nxt_val[WIDTH-1] ? SMIN : SMAX) : add_raw;
      sub_res = sub_ovf ? (nxt_val[WIDTH-1] ? SMIN : SMAX) : sub_raw;
      mul_res = mul_ovf ? (mult_product[2*WIDTH-1] ? SMIN : SMAX)
                        : mult_product[WIDTH-1:0];
`else
      add_res = add_raw;
      sub_res = sub_raw;
      mul_res = mult_product[WIDTH-1:0];
`endif
   end

   assign mult_start = (state_q == StIdle) && op_valid && !reject && (opcode == OpMul);

   seq_mult #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (mult_start),
      .a       (nxt_val),
      .b       (top_q),
      .busy    (mult_busy),
      .done    (mult_done),
      .product (mult_product)
   );

   // Command FSM with registered status outputs and stack storage updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         top_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  if (reject) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     done_q <= (opcode != OpMul);
                     ovf_q  <= 1'b0;
                     case (opcode)
                        OpPush, OpDup: begin
                           mem[p_idx] <= (opcode == OpPush) ? input_data : top_q;
                           top_q      <= (opcode == OpPush) ? input_data : top_q;
                           count_q    <= cnt_inc;
                           empty_q    <= 1'b0;
                           full_q     <= (cnt_inc == CNT_W'(DEPTH));
                        end
                        OpPop: begin
                           top_q   <= (count_q > CNT_W'(1)) ? nxt_val : '0;
                           count_q <= cnt_dec;
                           empty_q <= (cnt_dec == '0);
                           full_q  <= 1'b0;
                        end
                        OpAdd, OpSub: begin
                           mem[n_idx] <= (opcode == OpAdd) ? add_res : sub_res;
                           top_q      <= (opcode == OpAdd) ? add_res : sub_res;
                           ovf_q      <= (opcode == OpAdd) ? add_ovf : sub_ovf;
                           count_q    <= cnt_dec;
                           empty_q    <= 1'b0;
                           full_q     <= 1'b0;
                        end
                        OpSwap: begin
                           mem[t_idx] <= nxt_val;
                           mem[n_idx] <= top_q;
                           top_q      <= nxt_val;
                        end
                        OpClr: begin
                           top_q   <= '0;
                           count_q <= '0;
                           empty_q <= 1'b1;
                           full_q  <= 1'b0;
                        end
                        OpMul: begin
                           state_q <= StMulRun;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            StMulRun: begin
               if (mult_busy && mult_done) begin
                  state_q <= StMulWb;
               end
            end
            StMulWb: begin
               mem[n_idx] <= mul_res;
               top_q      <= mul_res;
               ovf_q      <= mul_ovf;
               count_q    <= cnt_dec;
               empty_q    <= 1'b0;
               full_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign op_ready    = (state_q == StIdle);
   assign output_data = top_q;
   assign done        = done_q;
   assign err         = err_q;
   assign overflow    = ovf_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign count       = count_q;

endmodule

// File: tb/tb_stack_machine.sv
// Self-checking bench for stack_machine: directed plan steps plus random commands
// compared against a queue-based reference model.
module tb_stack_machine;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_PUSH = 4'b0110;
   localparam logic [3:0] OP_POP  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_DUP  = 4'b1001;
   localparam logic [3:0] OP_SWAP = 4'b1010;
   localparam logic [3:0] OP_CLR  = 4'b1011;

   localparam longint SMAXL = 64'sd2147483647;
   localparam longint SMINL = -64'sd2147483648;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [3:0]       opcode = 4'b0;
   logic [WIDTH-1:0] input_data = '0;
   logic [WIDTH-1:0] output_data;
   logic             done, err, overflow, empty, full;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int mq[$];
   bit m_ovf = 1'b0;
   bit e_err;
   bit e_mul;

   always #5 clk = ~clk;

   stack_machine #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .opcode      (opcode),
      .input_data  (input_data),
      .output_data (output_data),
      .done        (done),
      .err         (err),
      .overflow    (overflow),
      .empty       (empty),
      .full        (full),
      .count       (count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int fit(input longint r);
`ifdef STACK_SAT_EN
      if (r > SMAXL) return 32'h7fffffff;
      if (r < SMINL) return 32'h80000000;
`endif
      return int'(r);
   endfunction

   // Apply one command to the model; sets e_err / e_mul.
   task automatic model_apply(input logic [3:0] opc, input logic [31:0] d);
      longint n, t, r;
      int sz, tmp;
      sz = mq.size();
      e_err = 1'b0;
      e_mul = 1'b0;
      case (opc)
         OP_NOP: m_ovf = 1'b0;
         OP_PUSH, OP_DUP: begin
            if (sz == DEPTH) e_err = 1'b1;
            else begin
               if (opc == OP_PUSH) mq.push_back(int'(d));
               else mq.push_back(mq[sz-1]);
               m_ovf = 1'b0;
            end
         end
         OP_POP: begin
            if (sz == 0) e_err = 1'b1;
            else begin
               tmp = mq.pop_back();
               m_ovf = 1'b0;
            end
         end
         OP_ADD, OP_SUB, OP_MUL: begin
            if (sz < 2) e_err = 1'b1;
            else begin
               t = longint'(mq.pop_back());
               n = longint'(mq.pop_back());
               if (opc == OP_ADD) r = n + t;
               else if (opc == OP_SUB) r = n - t;
               else r = n * t;
               m_ovf = (r > SMAXL) || (r < SMINL);
               mq.push_back(fit(r));
               e_mul = (opc == OP_MUL);
            end
         end
         OP_SWAP: begin
            if (sz < 2) e_err = 1'b1;
            else begin
               tmp = mq[sz-1];
               mq[sz-1] = mq[sz-2];
               mq[sz-2] = tmp;
               m_ovf = 1'b0;
            end
         end
         OP_CLR: begin
            mq.delete();
            m_ovf = 1'b0;
         end
         default: e_err = 1'b1;
      endcase
   endtask

   // Issue one command, wait (bounded) for done, compare against the model.
   task automatic do_op(input logic [3:0] opc, input logic [31:0] d, input string tag);
      int lat, low, sz;
      bit got;
      model_apply(opc, d);
      @(negedge clk);
      check({tag, ":ready_before"}, 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      opcode = opc;
      input_data = d;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      opcode = 4'($urandom);
      input_data = $urandom;
      lat = 0;
      low = 0;
      got = 1'b0;
      while (!got && lat < int'(WIDTH) + 10) begin
         @(negedge clk);
         lat++;
         if (done) got = 1'b1;
         else if (!op_ready) low++;
      end
      sz = mq.size();
      check({tag, ":done_seen"}, 32'(got), 32'd1);
      check({tag, ":latency"}, 32'(lat), e_mul ? WIDTH + 2 : 32'd1);
      check({tag, ":ready_low"}, 32'(low), e_mul ? WIDTH + 1 : 32'd0);
      check({tag, ":err"}, 32'(err), 32'(e_err));
      check({tag, ":output_data"}, output_data, (sz > 0) ? mq[sz-1] : 32'd0);
      check({tag, ":count"}, 32'(count), 32'(sz));
      check({tag, ":empty"}, 32'(empty), 32'(sz == 0));
      check({tag, ":full"}, 32'(full), 32'(sz == DEPTH));
      check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
      @(negedge clk);
      check({tag, ":done_pulse"}, 32'(done), 32'd0);
   endtask

   function automatic logic [31:0] rand_data();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return 32'h7fffffff;
         1: return 32'h80000000;
         2: return 32'hffffffff;
         3, 4: return $urandom;
         default: return 32'($signed($urandom_range(0, 40)) - 20);
      endcase
   endfunction

   function automatic logic [3:0] rand_op();
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 30) return OP_PUSH;
      if (r < 40) return OP_POP;
      if (r < 50) return OP_ADD;
      if (r < 58) return OP_SUB;
      if (r < 65) return OP_MUL;
      if (r < 73) return OP_DUP;
      if (r < 81) return OP_SWAP;
      if (r < 84) return OP_CLR;
      if (r < 88) return OP_NOP;
      r = $urandom_range(0, 6);
      return (r < 3) ? 4'(r + 1) : 4'(r + 9);
   endfunction

   initial begin
      bit saw_done;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset:op_ready", 32'(op_ready), 32'd1);
      check("reset:done", 32'(done), 32'd0);
      check("reset:err", 32'(err), 32'd0);
      check("reset:overflow", 32'(overflow), 32'd0);
      check("reset:empty", 32'(empty), 32'd1);
      check("reset:full", 32'(full), 32'd0);
      check("reset:count", 32'(count), 32'd0);
      check("reset:output_data", output_data, 32'd0);

      // Fill to DEPTH, rejected extra push, DUP at DEPTH-1, drain, rejected pop
      for (int i = 1; i <= int'(DEPTH); i++) do_op(OP_PUSH, 32'(i), "fill");
      do_op(OP_PUSH, 32'd257, "push_full");
      do_op(OP_DUP, 32'd0, "dup_full");
      do_op(OP_POP, 32'd0, "pop_one");
      do_op(OP_DUP, 32'd0, "dup_depth_m1");
      for (int i = 0; i < int'(DEPTH); i++) do_op(OP_POP, 32'd0, "drain");
      do_op(OP_POP, 32'd0, "pop_empty");
      do_op(OP_ADD, 32'd0, "add_empty");
      do_op(OP_CLR, 32'd0, "clr_empty");

      // Directed arithmetic
      do_op(OP_PUSH, 32'd1, "p1");
      do_op(OP_PUSH, -32'sd2, "pm2");
      do_op(OP_ADD, 32'd0, "add_small");
      do_op(OP_MUL, 32'd0, "mul_one_entry");
      do_op(OP_PUSH, 32'h7fffffff, "pmax");
      do_op(OP_PUSH, 32'd1, "p1b");
      do_op(OP_ADD, 32'd0, "add_ovf");
      do_op(OP_CLR, 32'd0, "clr1");
      do_op(OP_PUSH, -32'sd3, "pm3");
      do_op(OP_PUSH, 32'd4, "p4");
      do_op(OP_MUL, 32'd0, "mul_m12");
      do_op(OP_PUSH, 32'h80000000, "pmin");
      do_op(OP_PUSH, 32'hffffffff, "pm1");
      do_op(OP_MUL, 32'd0, "mul_min_m1");
      do_op(OP_CLR, 32'd0, "clr2");
      do_op(OP_PUSH, 32'd5, "p5");
      do_op(OP_PUSH, 32'd9, "p9");
      do_op(OP_SWAP, 32'd0, "swap");
      do_op(OP_SUB, 32'd0, "sub");
      do_op(OP_DUP, 32'd0, "dup");
      do_op(OP_CLR, 32'd0, "clr3");
      do_op(4'b1111, 32'd0, "illegal");

      // Random commands against the model
      for (int i = 0; i < 400; i++) do_op(rand_op(), rand_data(), "rand");

      // Reset during MUL_RUN cycle 10
      do_op(OP_CLR, 32'd0, "pre_rst_clr");
      do_op(OP_PUSH, 32'd7, "pre_rst_p7");
      do_op(OP_PUSH, 32'd6, "pre_rst_p6");
      @(negedge clk);
      op_valid = 1'b1;
      opcode = OP_MUL;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      opcode = OP_NOP;
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("mulrst:ready_low", 32'(op_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      if (done) saw_done = 1'b1;
      rst = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      check("mulrst:op_ready", 32'(op_ready), 32'd1);
      check("mulrst:count", 32'(count), 32'd0);
      check("mulrst:empty", 32'(empty), 32'd1);
      check("mulrst:output_data", output_data, 32'd0);
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("mulrst:no_done", 32'(saw_done), 32'd0);
      do_op(OP_PUSH, 32'd11, "post_rst_p11");
      do_op(OP_PUSH, -32'sd2, "post_rst_pm2");
      do_op(OP_MUL, 32'd0, "post_rst_mul");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stack_machine.md
Name: stack_machine

Overview:
- Parametrised successor to the team's push/pop/add/multiply stack.
- Adds a valid/ready command handshake, a 4-bit opcode space with SUB/DUP/SWAP/CLR, explicit error signalling, and a multi-cycle shift-add multiplier.
- Acts as the evaluation engine for RPN-style command streams from the host-side sequencer.

Parameters:
- DEPTH, 256, number of stack entries (>=2).
- WIDTH, 32, signed data width (>=4).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  command present.
- op_ready  out  1  engine can accept a command.
- opcode  in  4  command code (see Behaviour).
- input_data  in  WIDTH  signed operand for PUSH.
- output_data  out  WIDTH  signed top of stack; 0 when empty.
- done  out  1  one-cycle pulse when a command completes or is rejected.
- err  out  1  one-cycle pulse with done when the command was rejected.
- overflow  out  1  signed overflow of the last completed ADD/SUB/MUL; held until the next completed command.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset values: op_ready=1, done=0, err=0, overflow=0, empty=1, full=0, count=0, output_data=0. Storage contents need not be cleared.
- Opcodes. Legacy codes are kept.
  - 0000 NOP
  - 0100 ADD
  - 0101 MUL
  - 0110 PUSH
  - 0111 POP
  - 1000 SUB
  - 1001 DUP
  - 1010 SWAP
  - 1011 CLR
  - Any other code is rejected with err.
- Operand naming: T=top, N=next.
  - ADD/SUB/MUL pop T and N, then push N op T (SUB = N-T).
  - The result is the low WIDTH bits of the true signed result; count drops by 1.
- Handshake:
  - A command is accepted on an edge where op_valid && op_ready.
  - input_data and opcode are sampled only at acceptance.
- FSM states:
  - IDLE: op_ready=1. Single-cycle ops update the stack at the acceptance edge; done pulses in the following cycle. MUL goes to MUL_RUN.
  - MUL_RUN: op_ready=0. Radix-2 shift-add on operand magnitudes for exactly WIDTH cycles, then goes to MUL_WB.
  - MUL_WB: apply sign, write the result, set overflow, pulse done, return to IDLE.
  - Accept-to-done latency: 1 cycle for single-cycle ops, WIDTH+2 cycles for MUL.
- Rejection rules. A rejected command leaves the stack, count and overflow unchanged; done and err pulse together 1 cycle after acceptance.
  - PUSH or DUP when full.
  - POP when empty.
  - ADD/SUB/MUL/SWAP with count<2.
  - Illegal opcode.
- Overflow flag:
  - ADD/SUB: set when the operand signs make overflow possible and the result sign differs.
  - MUL: set when the 2*WIDTH product does not fit in WIDTH signed bits.
  - Cleared by every other completed non-rejected command.
- Boundaries:
  - DUP at count=DEPTH-1 is legal and makes full=1.
  - MUL of -2^(WIDTH-1) by -1 sets overflow.
  - CLR always succeeds, including on an empty stack.
  - output_data, empty, full and count are registered and reflect post-command state in the same cycle as done.
- Reset mid-operation (including during MUL_RUN) aborts the command: no done, stack emptied, FSM to IDLE.

Optional Feature:
- Macro: STACK_SAT_EN.
- Defined: ADD/SUB/MUL results that overflow saturate to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) according to the true result sign. overflow is still set.
- Undefined: results wrap modulo 2^WIDTH.
- Handshake and latency are identical in both builds.

Decomposition:
- Package stack_machine_pkg holds:
  - opcode_e enum (4-bit) covering all codes above;
  - state_e enum (IDLE, MUL_RUN, MUL_WB);
  - a function for signed add/sub overflow detection.
- Sub-module seq_mult holds the WIDTH-cycle signed shift-add multiplier.
  - Ports: start/busy/done, a, b, product [2*WIDTH-1:0].
  - Instantiated once; stack_machine owns storage, pointer and FSM.

Test Plan:
- Reset, then PUSH 1..256 and one more PUSH 257 -> count=256, full=1; last PUSH gives done+err, output_data stays 256. Then 256 POPs -> empty=1; a further POP gives err.
- PUSH 1, PUSH -2, ADD -> output_data=-1, count=1, overflow=0; done 1 cycle after each accept.
- PUSH 2^31-1, PUSH 1, ADD -> overflow=1, output_data=-2^31 (wrap) or 2^31-1 with STACK_SAT_EN.
- PUSH -3, PUSH 4, MUL -> op_ready low for 33 cycles, done at accept+34, output_data=-12. PUSH -2^31, PUSH -1, MUL -> overflow=1.
- PUSH 5, PUSH 9, SWAP -> output_data=5; SUB -> output_data=4; DUP -> count=2; CLR -> empty=1, output_data=0; opcode 1111 -> err.
- Assert rst during MUL_RUN cycle 10 -> no done, count=0, op_ready=1 the cycle after reset releases.
